// File: rtl/axis_seq_pkg.sv
// ============================================================================
// Module : axis_seq_pkg
// Brief  : Shared types and sizing helpers for the AXIS frame sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package axis_seq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAM    = 2'd1,
        WAIT_DONE = 2'd2
    } seq_state_e;

    localparam int ERR_W = 16;

    // Beat index width for a given frame length; a 2-beat frame still needs one bit.
    function automatic int seq_beat_w(input int frame_len);
        return (frame_len <= 2) ? 1 : $clog2(frame_len);
    endfunction

endpackage : axis_seq_pkg

`default_nettype wire

// File: rtl/axis_frame_counter.sv
// ============================================================================
// Module : axis_frame_counter
// Brief  : Beat index counter with enable, terminal-count flag and sync clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axis_frame_counter #(
    parameter int LEN = 1024,
    parameter int W   = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_idx,
    output logic         o_tc
);

    localparam logic [W-1:0] c_last = W'(LEN - 1);

    logic [W-1:0] r_idx;

    assign o_idx = r_idx;
    assign o_tc  = (r_idx == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_en) begin
            r_idx <= o_tc ? '0 : r_idx + W'(1);
        end
    end

endmodule : axis_frame_counter

`default_nettype wire

// File: rtl/axis_frame_sequencer.sv
// ============================================================================
// Module : axis_frame_sequencer
// Brief  : Gates a DMA sample stream into fixed-length frames with generated
//          TLAST and a hard stall until the engine reports frame completion.
//          Optional TLAST cross-check enabled by macro FRAME_ERR_CHK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axis_frame_sequencer
    import axis_seq_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int FRAME_LEN = 1024,
    parameter int FCNT_W    = 16
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic [DATA_W-1:0] S_AXIS_TDATA,
    input  logic              S_AXIS_TVALID,
    input  logic              S_AXIS_TLAST,
    output logic              S_AXIS_TREADY,
    output logic [DATA_W-1:0] M_AXIS_TDATA,
    output logic              M_AXIS_TVALID,
    output logic              M_AXIS_TLAST,
    input  logic              M_AXIS_TREADY,
    input  logic              ctrl_run,
    input  logic              proc_done,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam int BEAT_W = seq_beat_w(FRAME_LEN);

    seq_state_e        r_state;
    seq_state_e        w_state_nxt;
    logic              w_streaming;
    logic              w_beat;
    logic              w_tc;
    logic              w_clr;
    logic [BEAT_W-1:0] w_beat_idx;
    logic [FCNT_W-1:0] r_frame_cnt;

    assign w_streaming = (r_state == STREAM);
    assign w_beat      = w_streaming && S_AXIS_TVALID && M_AXIS_TREADY;
    // The index only leaves zero inside a frame, so clearing in IDLE is purely defensive.
    assign w_clr       = (r_state == IDLE);

    axis_frame_counter #(
        .LEN (FRAME_LEN),
        .W   (BEAT_W)
    ) u_beat_cnt (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .i_clr (w_clr),
        .i_en  (w_beat),
        .o_idx (w_beat_idx),
        .o_tc  (w_tc)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        S_AXIS_TREADY = 1'b0;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TLAST  = 1'b0;
        case (r_state)
            IDLE: begin
                if (ctrl_run) w_state_nxt = STREAM;
            end
            STREAM: begin
                // Pure pass-through: TVALID follows upstream only, never M_AXIS_TREADY.
                S_AXIS_TREADY = M_AXIS_TREADY;
                M_AXIS_TVALID = S_AXIS_TVALID;
                M_AXIS_TLAST  = w_tc;
                if (w_beat && w_tc) w_state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (proc_done) w_state_nxt = ctrl_run ? STREAM : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign M_AXIS_TDATA = S_AXIS_TDATA;
    assign busy         = (r_state != IDLE);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_frame_cnt <= '0;
        end else if (w_beat && w_tc) begin
            r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
        end
    end

    assign frame_cnt = r_frame_cnt;

`ifdef FRAME_ERR_CHK_EN
    logic [ERR_W-1:0] r_err_cnt;
    logic             w_mismatch;

    assign w_mismatch = w_beat && (S_AXIS_TLAST != w_tc);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_err_cnt <= '0;
        end else if (w_mismatch && (r_err_cnt != {ERR_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`else
    logic w_unused_tlast;

    assign w_unused_tlast = S_AXIS_TLAST;
    assign err_cnt        = '0;
`endif

endmodule : axis_frame_sequencer

`default_nettype wire
